turn_signal_sequencer: RTL and testbench

Controller that drives the turn-signal light FSM from raw driver switches. It synchronizes and arbitrates left/right/hazard/clear requests and emits the FSM's 4-bit active-low stimulus code. It also generates the FSM's step strobe `enable`; the FSM advances on the falling edge of `enable`. It sits between the board switch inputs and the light FSM.

---
 rtl/turn_signal_sequencer.sv | 156 +++++++++++++++
 tb/tb_turn_signal_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/turn_signal_sequencer.sv
// Turn-signal sequencer: synchronizes/arbitrates driver switches and strobes the light FSM.
// Optional input debounce filter is compiled in with `define TURN_SIGNAL_DEBOUNCE_EN.
module turn_signal_sequencer #(
  parameter int TICK_DIV        = 12_500_000,
  parameter int DRAIN_STEPS     = 3,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_req,
  input  logic       clear_req,
  output logic [3:0] stimulus,
  output logic       enable,
  output logic       busy,
  output logic [2:0] state_dbg
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = (DRAIN_STEPS > 1) ? $clog2(DRAIN_STEPS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEFT   = 3'd1;
  localparam logic [2:0] S_RIGHT  = 3'd2;
  localparam logic [2:0] S_HAZARD = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_CLEAR  = 3'd5;

  // Request bit order: {clear, hazard, right, left}
  logic [3:0] raw, sync1, sync2, req;
  assign raw = {clear_req, hazard_req, right_req, left_req};

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef TURN_SIGNAL_DEBOUNCE_EN
  localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  for (genvar i = 0; i < 4; i++) begin : g_db
    logic [BW-1:0] cnt;
    logic          filt;
    // Counts consecutive cycles the input disagrees with the filtered value.
    always_ff @(posedge clock) begin
      if (!reset) begin
        cnt  <= '0;
        filt <= 1'b0;
      end else if (sync2[i] == filt) begin
        cnt <= '0;
      end else if (cnt == BW'(DEBOUNCE_CYCLES - 1)) begin
        cnt  <= '0;
        filt <= sync2[i];
      end else begin
        cnt <= cnt + BW'(1);
      end
    end
    assign req[i] = filt;
  end
`else
  // No filter: DEBOUNCE_CYCLES is a non-negative count, so the mask is all ones.
  assign req = sync2 & {4{DEBOUNCE_CYCLES >= 0}};
`endif

  logic lreq, rreq, haz, clr;
  assign {clr, haz, rreq, lreq} = req;

  logic [2:0]    state, arb, nxt;
  logic [TW-1:0] tick, tick_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic          clear_cnt, clear_nxt;

  function automatic logic is_active(input logic [2:0] s);
    return (s == S_LEFT) || (s == S_RIGHT) || (s == S_HAZARD) || (s == S_DRAIN);
  endfunction

  function automatic logic [3:0] encode(input logic [2:0] s);
    case (s)
      S_LEFT:   return 4'b0111;
      S_RIGHT:  return 4'b1110;
      S_HAZARD: return 4'b1011;
      S_CLEAR:  return 4'b1101;
      default:  return 4'b1111;
    endcase
  endfunction

  always_comb begin
    arb = S_IDLE;
    if (clr) begin
      arb = S_CLEAR;
    end else if (state == S_CLEAR) begin
      arb = clear_cnt ? S_IDLE : S_CLEAR;
    end else if (haz) begin
      arb = S_HAZARD;
    end else begin
      case (state)
        S_LEFT:   arb = lreq ? S_LEFT : S_DRAIN;
        S_RIGHT:  arb = rreq ? S_RIGHT : S_DRAIN;
        S_HAZARD: arb = S_DRAIN;
        S_IDLE, S_DRAIN: begin
          if (lreq)      arb = S_LEFT;
          else if (rreq) arb = S_RIGHT;
          else if (state == S_DRAIN && !enable && drain_cnt == DW'(DRAIN_STEPS - 1))
            arb = S_IDLE;
          else           arb = state;
        end
        default:  arb = S_IDLE;
      endcase
    end
  end

  always_comb begin
    nxt = arb;
    // Hold the code steady across the low strobe: a change landing on a step edge waits one cycle.
    if (is_active(state) && is_active(arb) && arb != state && tick == TW'(TICK_DIV - 2))
      nxt = state;

    tick_nxt = '0;
    if (is_active(nxt)) begin
      if (!is_active(state))                  tick_nxt = TW'(TICK_DIV - 2);
      else if (tick == TW'(TICK_DIV - 1))     tick_nxt = '0;
      else                                    tick_nxt = tick + TW'(1);
    end

    drain_nxt = '0;
    if (nxt == S_DRAIN && state == S_DRAIN)
      drain_nxt = enable ? drain_cnt : drain_cnt + DW'(1);

    clear_nxt = (nxt == S_CLEAR) && (state == S_CLEAR) && !clr;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      tick      <= '0;
      drain_cnt <= '0;
      clear_cnt <= 1'b0;
      stimulus  <= 4'b1111;
      enable    <= 1'b1;
    end else begin
      state     <= nxt;
      tick      <= tick_nxt;
      drain_cnt <= drain_nxt;
      clear_cnt <= clear_nxt;
      stimulus  <= encode(nxt);
      enable    <= !(is_active(nxt) && tick_nxt == TW'(TICK_DIV - 1));
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;
endmodule

// File: tb/tb_turn_signal_sequencer.sv
// Directed bench for turn_signal_sequencer (TICK_DIV=4, DRAIN_STEPS=3, no debounce).
// Drivers push per-cycle expected {busy, enable, stimulus}; a negedge monitor pops and compares.
module tb_turn_signal_sequencer;
  localparam int TICK = 4;
  localparam logic [3:0] C_NONE = 4'b1111;
  localparam logic [3:0] C_LEFT = 4'b0111;
  localparam logic [3:0] C_RIGHT = 4'b1110;
  localparam logic [3:0] C_HAZ = 4'b1011;
  localparam logic [3:0] C_RST = 4'b1101;
  localparam int W = 22;  // {cycle[15:0], busy, enable, stimulus[3:0]}

  logic       clock, reset;
  logic       left_req, right_req, hazard_req, clear_req;
  logic [3:0] stimulus;
  logic       enable, busy;
  logic [2:0] state_dbg;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  string        name_q[$];

  turn_signal_sequencer #(
    .TICK_DIV(TICK), .DRAIN_STEPS(3), .DEBOUNCE_CYCLES(2)
  ) dut (
    .clock(clock), .reset(reset),
    .left_req(left_req), .right_req(right_req),
    .hazard_req(hazard_req), .clear_req(clear_req),
    .stimulus(stimulus), .enable(enable), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock / cycle counter
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Driver helpers
  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  // base < 0: enable held high; else enable low on cycles base, base+TICK, ...
  task automatic push_span(input int from, input int to, input logic [3:0] stim,
                           input logic bsy, input int base, input string nm);
    for (int c = from; c <= to; c++) begin
      int   ph;
      logic en;
      int   cv;
      ph = (((c - base) % TICK) + TICK) % TICK;
      en = (base < 0) ? 1'b1 : (ph != 0);
      cv = c;
      exp_q.push_back({cv[15:0], bsy, en, stim});
      name_q.push_back(nm);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    while (exp_q.size() > 0 && int'(exp_q[0][21:6]) <= cyc) begin
      logic [W-1:0] e;
      string        nm;
      logic [5:0]   act;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {busy, enable, stimulus};
      vectors++;
      if (int'(e[21:6]) != cyc) begin
        miscompares++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)", nm, e[21:6], cyc);
      end else if (act !== e[5:0]) begin
        miscompares++;
        $display("FAIL %s @cycle %0d: busy/en/stim got %b expected %b", nm, cyc, act, e[5:0]);
      end
    end
  end

  initial begin : stim_main
    int t, t2, p0, r, d, s, p1, h, c0, q;
    reset = 1'b0;
    left_req = 1'b0; right_req = 1'b0; hazard_req = 1'b0; clear_req = 1'b0;

    // Reset low for two edges, then idle for 20 cycles
    go_to(2);
    reset = 1'b1;
    t = cyc;
    push_span(t, t + 19, C_NONE, 1'b0, -1, "reset_idle");

    // Left: code 3 cycles after raise, first step 1 cycle later, period 4
    t2 = t + 21;
    go_to(t2);
    left_req = 1'b1;
    p0 = t2 + 4;
    push_span(t2 + 1, t2 + 2, C_NONE, 1'b0, -1, "left_latency");
    push_span(t2 + 3, t2 + 12, C_LEFT, 1'b1, p0, "left_run");

    // Right while left owns: ignored
    r = t2 + 13;
    go_to(r);
    right_req = 1'b1;
    push_span(r, r + 8, C_LEFT, 1'b1, p0, "left_lock");

    // Drop both: drain issues exactly 3 pulses, then idle
    d = r + 9;
    go_to(d);
    left_req = 1'b0;
    right_req = 1'b0;
    push_span(d, d + 2, C_LEFT, 1'b1, p0, "left_tail");
    push_span(d + 3, p0 + 32, C_NONE, 1'b1, p0, "drain");
    push_span(p0 + 33, p0 + 36, C_NONE, 1'b0, -1, "drain_done");

    // Left+right together -> left; hazard raised so its change lands on a step edge (deferred)
    s = p0 + 37;
    go_to(s);
    left_req = 1'b1;
    right_req = 1'b1;
    p1 = s + 4;
    push_span(s, s + 2, C_NONE, 1'b0, -1, "both_latency");
    push_span(s + 3, s + 8, C_LEFT, 1'b1, p1, "both_left");
    h = s + 9;
    go_to(h);
    hazard_req = 1'b1;
    push_span(h, h + 3, C_LEFT, 1'b1, p1, "haz_defer");
    push_span(h + 4, h + 12, C_HAZ, 1'b1, p1, "hazard_run");

    // One-cycle clear pulse during hazard; all requests released
    c0 = h + 13;
    go_to(c0);
    clear_req = 1'b1;
    push_span(c0, c0 + 2, C_HAZ, 1'b1, p1, "pre_clear");
    go_to(c0 + 1);
    clear_req = 1'b0;
    hazard_req = 1'b0;
    left_req = 1'b0;
    right_req = 1'b0;
    push_span(c0 + 3, c0 + 4, C_RST, 1'b1, -1, "clear_code");
    push_span(c0 + 5, c0 + 8, C_NONE, 1'b0, -1, "clear_idle");

    // Right, then reset asserted on a step cycle
    q = c0 + 9;
    go_to(q);
    right_req = 1'b1;
    push_span(q, q + 2, C_NONE, 1'b0, -1, "right_latency");
    push_span(q + 3, q + 8, C_RIGHT, 1'b1, q + 4, "right_run");
    go_to(q + 8);
    reset = 1'b0;
    right_req = 1'b0;
    push_span(q + 9, q + 14, C_NONE, 1'b0, -1, "mid_reset");
    go_to(q + 10);
    reset = 1'b1;
    go_to(q + 15);

    // Bounded wait for the scoreboard to empty
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clock);
    if (exp_q.size() > 0) begin
      $display("FAIL drain_queue: %0d expectations left unchecked, required 0", exp_q.size());
      miscompares += exp_q.size();
    end
    @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
